// File: rtl/scratch_pkg.sv
// rtl/scratch_pkg.sv - shared types and constants for the scratch spill/fill engine
package scratch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned SLOT_BASE = 64;
    localparam int unsigned NSLOT     = 8;

    localparam logic DIR_SPILL = 1'b0;
    localparam logic DIR_FILL  = 1'b1;

endpackage

// File: rtl/scratch_spill_ctrl_if.sv
// rtl/scratch_spill_ctrl_if.sv - control, core, DataMem and regfile signals of the spill engine
interface scratch_spill_ctrl_if #(
    parameter int DW    = 8,
    parameter int AW    = 10,
    parameter int NSLOT = 8
);
    logic             Start;
    logic             Dir;
    logic [NSLOT-1:0] Mask;
    logic             Busy;
    logic             Done;

    logic             CoreReq;
    logic [AW-1:0]    CoreAddr;
    logic             CoreWrEn;
    logic [DW-1:0]    CoreWrData;

    logic [AW-1:0]    DmAddr;
    logic             DmWrEn;
    logic [DW-1:0]    DmWrData;
    logic [DW-1:0]    DmRdData;

    logic [2:0]       RegAddr;
    logic [DW-1:0]    RegRdData;
    logic             RegWrEn;
    logic [DW-1:0]    RegWrData;

    modport slave (
        input  Start, Dir, Mask,
        output Busy, Done,
        input  CoreReq, CoreAddr, CoreWrEn, CoreWrData,
        output DmAddr, DmWrEn, DmWrData,
        input  DmRdData,
        output RegAddr,
        input  RegRdData,
        output RegWrEn, RegWrData
    );

    modport master (
        output Start, Dir, Mask,
        input  Busy, Done,
        output CoreReq, CoreAddr, CoreWrEn, CoreWrData,
        input  DmAddr, DmWrEn, DmWrData,
        output DmRdData,
        input  RegAddr,
        output RegRdData,
        input  RegWrEn, RegWrData
    );
endinterface

// File: rtl/LUT_dm.sv
// rtl/LUT_dm.sv - scratch slot index to DataMem address lookup
module LUT_dm
    import scratch_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic [2:0]    idx,
    output logic [AW-1:0] addr
);

    // Slots sit contiguously above the scratch base
    always_comb begin
        addr = AW'(SLOT_BASE) + AW'(idx);
    end

endmodule

// File: rtl/scratch_spill_ctrl.sv
// rtl/scratch_spill_ctrl.sv - spills/fills selected scratch slots through the shared DataMem port
module scratch_spill_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 10,
    parameter int NSLOT = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    scratch_spill_ctrl_if.slave   bus
);
    import scratch_pkg::*;

    state_t           state_q, state_d;
    logic [NSLOT-1:0] wm_q, wm_d;
    logic             dir_q, dir_d;

    logic [2:0]       idx;
    logic [AW-1:0]    slot_addr;
    logic             xfer_go;
    logic [NSLOT-1:0] clr_bit;
    logic [DW-1:0]    spill_data;

    // Lowest set bit wins so slots go out in ascending order
    function automatic logic [2:0] lowest_set(input logic [NSLOT-1:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign idx        = lowest_set(wm_q);
    assign spill_data = bus.RegRdData;

    LUT_dm #(.AW(AW)) u_lut (
        .idx  (idx),
        .addr (slot_addr)
    );

    // State, working mask and direction registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            wm_q    <= '0;
            dir_q   <= DIR_SPILL;
        end else begin
            state_q <= state_d;
            wm_q    <= wm_d;
            dir_q   <= dir_d;
        end
    end

    // Next state plus the DataMem/regfile port mux; the core always owns the port when it asks
    always_comb begin
        state_d       = state_q;
        wm_d          = wm_q;
        dir_d         = dir_q;
        xfer_go       = 1'b0;
        clr_bit       = '0;
        clr_bit[idx]  = 1'b1;

        bus.Busy      = (state_q != IDLE);
        bus.Done      = (state_q == DONE);
        bus.RegAddr   = '0;
        bus.RegWrEn   = 1'b0;
        bus.RegWrData = '0;
        bus.DmAddr    = '0;
        bus.DmWrEn    = 1'b0;
        bus.DmWrData  = '0;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    dir_d   = bus.Dir;
                    wm_d    = bus.Mask;
                    state_d = (bus.Mask != '0) ? XFER : DONE;
                end
            end
            XFER: begin
                bus.RegAddr = idx;
                if (!bus.CoreReq) begin
                    xfer_go = 1'b1;
                    wm_d    = wm_q & ~clr_bit;
                    if (wm_d == '0) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.CoreReq) begin
            bus.DmAddr   = bus.CoreAddr;
            bus.DmWrEn   = bus.CoreWrEn;
            bus.DmWrData = bus.CoreWrData;
        end else if (xfer_go) begin
            bus.DmAddr = slot_addr;
            if (dir_q == DIR_SPILL) begin
                bus.DmWrEn   = 1'b1;
                bus.DmWrData = spill_data;
            end else begin
                bus.RegWrEn   = 1'b1;
                bus.RegWrData = bus.DmRdData;
            end
        end
    end

endmodule

// File: tb/tb_scratch_spill_ctrl.sv
// tb/tb_scratch_spill_ctrl.sv - self-checking bench for scratch_spill_ctrl
module tb_scratch_spill_ctrl;

    logic Clk;
    logic Reset;

    scratch_spill_ctrl_if #(.DW(8), .AW(10), .NSLOT(8)) bus ();

    scratch_spill_ctrl #(.DW(8), .AW(10), .NSLOT(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory and register file models
    logic [7:0] dmem [0:1023];
    logic [7:0] regs [0:7];

    assign bus.DmRdData  = dmem[bus.DmAddr];
    assign bus.RegRdData = regs[bus.RegAddr];

    logic       p_dwe, p_rwe;
    logic [9:0] p_dad;
    logic [2:0] p_rad;
    logic [7:0] p_dwd, p_rwd;

    always @(negedge Clk) begin
        p_dwe = Reset && bus.DmWrEn;
        p_dad = bus.DmAddr;
        p_dwd = bus.DmWrData;
        p_rwe = Reset && bus.RegWrEn;
        p_rad = bus.RegAddr;
        p_rwd = bus.RegWrData;
    end

    always @(posedge Clk) begin
        if (p_dwe === 1'b1) dmem[p_dad] = p_dwd;
        if (p_rwe === 1'b1) regs[p_rad] = p_rwd;
    end

    // Scoreboard of engine transfers
    typedef struct {
        logic       fill;
        logic [2:0] slot;
        logic [7:0] data;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t mon_e;

    always @(negedge Clk) begin
        if (Reset && !bus.CoreReq && (bus.DmWrEn || bus.RegWrEn)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_xfer: got DmWrEn=%0b RegWrEn=%0b DmAddr=%0h expected none at %0t",
                         bus.DmWrEn, bus.RegWrEn, bus.DmAddr, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("xfer_regwren", 32'(bus.RegWrEn), 32'(mon_e.fill));
                chk("xfer_dmwren",  32'(bus.DmWrEn),  32'(!mon_e.fill));
                if (mon_e.fill) begin
                    chk("fill_regaddr", 32'(bus.RegAddr),   32'(mon_e.slot));
                    chk("fill_dmaddr",  32'(bus.DmAddr),    32'(64 + int'(mon_e.slot)));
                    chk("fill_data",    32'(bus.RegWrData), 32'(mon_e.data));
                end else begin
                    chk("spill_addr", 32'(bus.DmAddr),   32'(64 + int'(mon_e.slot)));
                    chk("spill_data", 32'(bus.DmWrData), 32'(mon_e.data));
                end
            end
        end
    end

    // Port pass-through vectors applied in IDLE
    typedef struct {
        logic       core_req;
        logic [9:0] core_addr;
        logic       core_wren;
        logic [7:0] core_wdata;
        logic [9:0] exp_addr;
        logic       exp_wren;
        logic [7:0] exp_wdata;
    } vec_t;

    vec_t vecs [5];

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic fill, input int slot, input logic [7:0] data);
        xfer_t e;
        e.fill = fill;
        e.slot = 3'(slot);
        e.data = data;
        exp_q.push_back(e);
    endtask

    int done_cnt;

    initial begin
        vecs[0] = '{1'b1, 10'd3,   1'b1, 8'h5A, 10'd3,   1'b1, 8'h5A};
        vecs[1] = '{1'b1, 10'd900, 1'b0, 8'hFF, 10'd900, 1'b0, 8'hFF};
        vecs[2] = '{1'b0, 10'd67,  1'b1, 8'hC3, 10'd0,   1'b0, 8'h00};
        vecs[3] = '{1'b1, 10'd66,  1'b1, 8'h81, 10'd66,  1'b1, 8'h81};
        vecs[4] = '{1'b0, 10'd1023,1'b0, 8'h00, 10'd0,   1'b0, 8'h00};

        for (int i = 0; i < 1024; i++) dmem[i] = 8'h00;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;

        Reset          = 1'b0;
        bus.Start      = 1'b1;
        bus.Dir        = 1'b0;
        bus.Mask       = 8'hFF;
        bus.CoreReq    = 1'b0;
        bus.CoreAddr   = '0;
        bus.CoreWrEn   = 1'b0;
        bus.CoreWrData = '0;

        // Reset held with Start asserted
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            chk("rst_busy",    32'(bus.Busy),    32'd0);
            chk("rst_done",    32'(bus.Done),    32'd0);
            chk("rst_dmwren",  32'(bus.DmWrEn),  32'd0);
            chk("rst_regwren", 32'(bus.RegWrEn), 32'd0);
            chk("rst_dmaddr",  32'(bus.DmAddr),  32'd0);
        end
        step();
        bus.Start = 1'b0;
        bus.Mask  = 8'h00;
        Reset     = 1'b1;
        step();

        // Core pass-through and idle port values
        for (int i = 0; i < 5; i++) begin
            bus.CoreReq    = vecs[i].core_req;
            bus.CoreAddr   = vecs[i].core_addr;
            bus.CoreWrEn   = vecs[i].core_wren;
            bus.CoreWrData = vecs[i].core_wdata;
            @(negedge Clk);
            chk("vec_dmaddr",  32'(bus.DmAddr),   32'(vecs[i].exp_addr));
            chk("vec_dmwren",  32'(bus.DmWrEn),   32'(vecs[i].exp_wren));
            chk("vec_dmwdata", 32'(bus.DmWrData), 32'(vecs[i].exp_wdata));
            chk("vec_regwren", 32'(bus.RegWrEn),  32'd0);
            chk("vec_busy",    32'(bus.Busy),     32'd0);
            step();
        end
        bus.CoreReq  = 1'b0;
        bus.CoreWrEn = 1'b0;
        for (int i = 64; i < 72; i++) dmem[i] = 8'h00;

        // Full spill of all eight slots
        for (int i = 0; i < 8; i++) begin
            regs[i] = 8'(8'h10 + i);
            push(1'b0, i, 8'(8'h10 + i));
        end
        bus.Dir   = 1'b0;
        bus.Mask  = 8'hFF;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        bus.Mask  = 8'h00;
        bus.Dir   = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            chk("spill_busy", 32'(bus.Busy), 32'd1);
            chk("spill_done", 32'(bus.Done), 32'd0);
            step();
        end
        @(negedge Clk);
        chk("spill_done_pulse", 32'(bus.Done), 32'd1);
        chk("spill_done_busy",  32'(bus.Busy), 32'd1);
        step();
        @(negedge Clk);
        chk("spill_after_done", 32'(bus.Done), 32'd0);
        chk("spill_after_busy", 32'(bus.Busy), 32'd0);
        chk("spill_q_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) chk("spill_mem", 32'(dmem[64 + i]), 32'(8'h10 + i));
        step();

        // Sparse fill with a core stall in the first transfer cycle
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        dmem[65] = 8'hA5;
        dmem[70] = 8'h3C;
        push(1'b1, 1, 8'hA5);
        push(1'b1, 6, 8'h3C);
        bus.Dir   = 1'b1;
        bus.Mask  = 8'b0100_0010;
        bus.Start = 1'b1;
        step();
        bus.Start      = 1'b0;
        bus.Dir        = 1'b0;
        bus.Mask       = 8'hFF;
        bus.CoreReq    = 1'b1;
        bus.CoreAddr   = 10'd5;
        bus.CoreWrEn   = 1'b1;
        bus.CoreWrData = 8'h77;
        @(negedge Clk);
        chk("stall_dmaddr",  32'(bus.DmAddr),   32'd5);
        chk("stall_dmwren",  32'(bus.DmWrEn),   32'd1);
        chk("stall_dmwdata", 32'(bus.DmWrData), 32'h77);
        chk("stall_regwren", 32'(bus.RegWrEn),  32'd0);
        chk("stall_busy",    32'(bus.Busy),     32'd1);
        step();
        bus.CoreReq  = 1'b0;
        bus.CoreWrEn = 1'b0;
        @(negedge Clk);
        chk("fill_k2_done", 32'(bus.Done), 32'd0);
        step();
        @(negedge Clk);
        chk("fill_k3_done", 32'(bus.Done), 32'd0);
        step();
        @(negedge Clk);
        chk("fill_k4_done", 32'(bus.Done), 32'd1);
        step();
        chk("fill_r1",      32'(regs[1]), 32'hA5);
        chk("fill_r6",      32'(regs[6]), 32'h3C);
        chk("fill_r0",      32'(regs[0]), 32'h00);
        chk("fill_core_wr", 32'(dmem[5]), 32'h77);
        chk("fill_q_empty", 32'(exp_q.size()), 32'd0);
        bus.Mask = 8'h00;

        // Empty mask: immediate Done, Start in DONE ignored
        bus.Dir   = 1'b0;
        bus.Mask  = 8'h00;
        bus.Start = 1'b1;
        step();
        bus.Mask = 8'hFF;
        @(negedge Clk);
        chk("m0_done", 32'(bus.Done), 32'd1);
        chk("m0_busy", 32'(bus.Busy), 32'd1);
        step();
        bus.Start = 1'b0;
        bus.Mask  = 8'h00;
        done_cnt  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (bus.Done) done_cnt++;
            step();
        end
        chk("m0_no_second_done", 32'(done_cnt), 32'd0);
        chk("m0_idle_busy", 32'(bus.Busy), 32'd0);

        // Start held through XFER is ignored
        for (int i = 0; i < 8; i++) regs[i] = 8'(8'h20 + i);
        push(1'b0, 0, 8'h20);
        push(1'b0, 1, 8'h21);
        bus.Dir   = 1'b0;
        bus.Mask  = 8'h03;
        bus.Start = 1'b1;
        step();
        bus.Mask = 8'hFF;
        bus.Dir  = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (bus.Done) done_cnt++;
            step();
            if (c == 1) begin
                bus.Start = 1'b0;
                bus.Mask  = 8'h00;
            end
        end
        chk("busy_start_one_done", 32'(done_cnt), 32'd1);
        chk("busy_start_q_empty",  32'(exp_q.size()), 32'd0);

        // Abort after three spill transfers
        for (int i = 64; i < 72; i++) dmem[i] = 8'h00;
        for (int i = 0; i < 8; i++) regs[i] = 8'(8'h10 + i);
        for (int i = 0; i < 3; i++) push(1'b0, i, 8'(8'h10 + i));
        bus.Dir   = 1'b0;
        bus.Mask  = 8'hFF;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        chk("abort_busy",    32'(bus.Busy),    32'd0);
        chk("abort_done",    32'(bus.Done),    32'd0);
        chk("abort_dmwren",  32'(bus.DmWrEn),  32'd0);
        chk("abort_dmaddr",  32'(bus.DmAddr),  32'd0);
        chk("abort_regwren", 32'(bus.RegWrEn), 32'd0);
        chk("abort_regaddr", 32'(bus.RegAddr), 32'd0);
        repeat (2) step();
        bus.Mask = 8'h00;
        Reset    = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 8; i++)
            chk("abort_mem", 32'(dmem[64 + i]), (i < 3) ? 32'(8'h10 + i) : 32'd0);
        chk("abort_q_empty", 32'(exp_q.size()), 32'd0);
        chk("abort_idle_busy", 32'(bus.Busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scratch_spill_ctrl.md
# scratch_spill_ctrl

Sequencer that spills register-file temporaries into the eight DataMem scratch slots (addresses 64–71) and fills them back. It shares the single DataMem port with the core's load/store path. Sits between the register file, the core memory stage and DataMem; slot index→address translation uses the team's existing slot lookup (LUT_dm). The core always has priority; the engine moves one slot per free cycle.

## Interface
- DW, 8, data width of register file and DataMem
- AW, 10, DataMem address width
- NSLOT, 8, number of scratch slots (fixed to LUT depth)
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  begin operation; sampled only in IDLE
- Dir  in  1  0 = spill (reg→mem), 1 = fill (mem→reg); sampled with Start
- Mask  in  NSLOT  slot i selected when Mask[i]=1; sampled with Start
- Busy  out  1  engine active (XFER or DONE)
- Done  out  1  one-cycle completion pulse
- CoreReq  in  1  core memory access this cycle
- CoreAddr  in  AW  core address
- CoreWrEn  in  1  core write enable
- CoreWrData  in  DW  core write data
- DmAddr  out  AW  DataMem address
- DmWrEn  out  1  DataMem write enable
- DmWrData  out  DW  DataMem write data
- DmRdData  in  DW  DataMem combinational read data (same cycle as DmAddr)
- RegAddr  out  3  register index (= slot index)
- RegRdData  in  DW  register file combinational read data
- RegWrEn  out  1  register write enable
- RegWrData  out  DW  register write data (= DmRdData)

## Operation
- States: IDLE, XFER, DONE.
- IDLE, Start=1: latch Dir and Mask into working mask WM. If Mask≠0, go to XFER; else go to DONE.
- XFER: idx = lowest set bit of WM (combinational priority encoder). RegAddr=idx. Engine address = LUT(idx) = 64+idx.
  - CoreReq=1 (stall): DataMem port goes to core; RegWrEn=0; WM unchanged.
  - CoreReq=0, spill: DmAddr=64+idx, DmWrEn=1, DmWrData=RegRdData.
  - CoreReq=0, fill: DmAddr=64+idx, DmWrEn=0, RegWrEn=1, RegWrData=DmRdData.
  - On a non-stalled cycle, clear WM[idx]. If that was the last set bit, go to DONE.
- DONE: Done=1 for one cycle, then IDLE.
- Port mux: CoreReq=1 → Dm* = Core*, in every state. CoreReq=0 and not transferring → DmAddr=0, DmWrEn=0, DmWrData=0.
- Start while Busy=1 is ignored.
- Dir/Mask changes after Start have no effect.
- Core accesses to addresses 64–71 during an operation are not blocked. Ordering is cycle order only.

## Timing
- Reset (async, Reset=0): state IDLE, WM=0, Dir latch 0. Busy=0, Done=0, DmWrEn=0, RegWrEn=0, DmAddr=0, DmWrData=0, RegAddr=0, RegWrData=0 (when CoreReq=0).
- Reset mid-operation aborts immediately. No further writes occur; slots already transferred stay written.
- Start sampled at edge k:
  - Busy=1 from cycle k+1 until Done deasserts.
  - N = popcount(Mask), S = stall cycles. Transfers occupy cycles k+1 … k+N+S; Done=1 in cycle k+N+S+1.
  - Mask=0: Done=1 in cycle k+1, no memory or register activity.
- Slots are transferred in ascending index order, exactly one per non-stalled XFER cycle.
- Outputs are combinational from state, WM and the Core*/RdData inputs. There is no registered data path, so spill data is the register value in the transfer cycle.
- Busy falls in the cycle after Done. A new Start is accepted at the edge ending the DONE cycle+1, i.e. in IDLE.

## Structure
- Shared package scratch_pkg: state enum (IDLE, XFER, DONE); SLOT_BASE=64; NSLOT=8; DIR_SPILL/DIR_FILL constants.
- One sub-module: the existing slot lookup LUT_dm (3-bit index → 10-bit address), instantiated once and driven by idx.
- Lowest-set-bit encoder is a local function; no separate module.

## Test plan
- Reset: hold Reset=0 with Start=1, Mask=8'hFF → Busy=0, Done=0, DmWrEn=0, RegWrEn=0 throughout.
- Full spill: registers r0–r7 = 8'h10…8'h17, Start, Dir=0, Mask=8'hFF, CoreReq=0 → DataMem[64..71] = 8'h10..8'h17 in cycles k+1..k+8; Done in k+9.
- Sparse fill with stall: DataMem[65]=8'hA5, DataMem[70]=8'h3C, Dir=1, Mask=8'b0100_0010, CoreReq=1 in cycle k+1 only → r1=8'hA5 in k+2, r6=8'h3C in k+3, Done in k+4. Core access is passed through in k+1.
- Mask=0: Start → Done in k+1, no DmWrEn/RegWrEn pulses. Start during Busy ignored (no second Done).
- Abort: Reset=0 asserted after 3 transfers of a Mask=8'hFF spill → only slots 64–66 written. Outputs are at reset values immediately.
